// File: rtl/spi_master_seq.sv
// spi_master_seq: SPI mode 0 (CPOL=0, CPHA=0), MSB-first transfer sequencer.
// Pops words from a TX FIFO, shifts them out on mosi with an SCLK of
// half-period clk_div+1, shifts miso into a word pushed to an RX FIFO, and
// holds cs_n low across back-to-back words.
// Ports:
//   clk, reset_b         system clock, synchronous active-low reset
//   enable               allow new words to be started
//   clk_div              SCLK half-period minus one, latched per word
//   tx_empty, tx_data    TX FIFO status and head word
//   tx_rd_en             TX FIFO pop (one-cycle pulse)
//   rx_full              RX FIFO full
//   rx_wr_en, rx_data    RX FIFO push and received word
//   sclk, mosi, miso     SPI bus
//   cs_n                 chip select, active low
//   busy                 high whenever not idle
module spi_master_seq #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CLK_DIV_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     enable,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     tx_empty,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_rd_en,
  input  logic                     rx_full,
  output logic                     rx_wr_en,
  output logic [DATA_WIDTH-1:0]    rx_data,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     cs_n,
  output logic                     busy
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WB, S_STALL} state_t;

  state_t                   state_q, state_d;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
  logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]    rx_shift_q, rx_shift_d;
  logic                     sclk_q, sclk_d;
  logic                     mosi_q, mosi_d;
  logic                     cs_n_q, cs_n_d;
  logic                     tx_rd_en_q, tx_rd_en_d;
  logic                     busy_q, busy_d;
  logic                     start_word;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_rd_en_d = 1'b0;
    busy_d     = busy_q;
    start_word = enable & ~tx_empty;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (start_word) begin
          state_d    = S_LOAD;
          tx_rd_en_d = 1'b1;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        // The head word is captured on the same edge that completes the pop.
        tx_shift_d = tx_data;
        mosi_d     = tx_data[DATA_WIDTH-1];
        div_d      = clk_div;
        cnt_d      = '0;
        sclk_d     = 1'b0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
            bit_cnt_d  = bit_cnt_q + BW'(1);
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = S_WB;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end else begin
          cnt_d = cnt_q + CLK_DIV_WIDTH'(1);
        end
      end
      S_WB, S_STALL: begin
        // STALL repeats the write-back decision every cycle until space frees.
        if (rx_full) begin
          state_d = S_STALL;
        end else if (start_word) begin
          state_d    = S_LOAD;
          tx_rd_en_d = 1'b1;
          bit_cnt_d  = '0;
        end else begin
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      tx_rd_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_rd_en_q <= tx_rd_en_d;
      busy_q     <= busy_d;
    end
  end

  // Push decided against the live rx_full so a push can never hit a full FIFO.
  assign rx_wr_en = ((state_q == S_WB) || (state_q == S_STALL)) && !rx_full;
  assign rx_data  = rx_shift_q;
  assign tx_rd_en = tx_rd_en_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_seq.sv
module tb_spi_master_seq;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] clk_div = '0;
  logic          tx_empty = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_rd_en;
  logic          rx_full = 1'b0;
  logic          rx_wr_en;
  logic [DW-1:0] rx_data;
  logic          sclk, mosi, miso, cs_n, busy;
  logic          inv = 1'b0;

  // Slave model: echoes mosi, optionally inverted.
  assign miso = inv ? ~mosi : mosi;

  always #5 clk = ~clk;

  spi_master_seq #(.DATA_WIDTH(DW), .CLK_DIV_WIDTH(CW)) dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .clk_div(clk_div),
    .tx_empty(tx_empty), .tx_data(tx_data), .tx_rd_en(tx_rd_en),
    .rx_full(rx_full), .rx_wr_en(rx_wr_en), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy)
  );

  logic [7:0]  txq[$];
  logic [7:0]  exp_w[$];
  logic [7:0]  exp_d[$];
  logic [7:0]  rx_got[$];
  logic [7:0]  mosi_got[$];
  logic [15:0] per_got[$];

  int unsigned cyc = 0, pops = 0, pushes = 0, bad_pop = 0, bad_push = 0;
  int unsigned rises = 0, cs_falls = 0, last_rise = 0, pmin = 0, pmax = 0, bitidx = 0;
  logic [7:0]  wmosi = '0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, pop_pending = 1'b0;
  int          n_checks = 0, n_pass = 0;
  int unsigned p0, q0, f0, r0;

  // Monitor and TX FIFO model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (pop_pending && txq.size() > 0) void'(txq.pop_front());
    pop_pending = 1'b0;
    tx_empty = (txq.size() == 0);
    tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
    if (tx_rd_en) begin
      pops++;
      if (tx_empty) bad_pop++;
      pop_pending = 1'b1;
      bitidx = 0;
      wmosi  = '0;
      pmin   = 1000;
      pmax   = 0;
    end
    if (rx_wr_en) begin
      pushes++;
      if (rx_full) bad_push++;
      rx_got.push_back(rx_data);
    end
    if (sclk && !sclk_prev) begin
      rises++;
      wmosi = {wmosi[6:0], mosi};
      if (bitidx > 0) begin
        if (cyc - last_rise < pmin) pmin = cyc - last_rise;
        if (cyc - last_rise > pmax) pmax = cyc - last_rise;
      end
      last_rise = cyc;
      bitidx++;
      if (bitidx == 8) begin
        mosi_got.push_back(wmosi);
        per_got.push_back({pmin[7:0], pmax[7:0]});
      end
    end
    if (!cs_n && cs_prev) cs_falls++;
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test();
    p0 = pops; q0 = pushes; f0 = cs_falls; r0 = rises;
    exp_w.delete(); exp_d.delete();
    rx_got.delete(); mosi_got.delete(); per_got.delete();
  endtask

  task automatic push_word(input logic [7:0] w, input logic [7:0] d);
    txq.push_back(w);
    exp_w.push_back(w);
    exp_d.push_back(d);
  endtask

  task automatic wait_rises(input string tag, input int unsigned n);
    logic ok;
    for (int i = 0; i < 2000; i++) begin
      if (rises - r0 >= n) break;
      tick(1);
    end
    ok = (rises - r0 >= n);
    chk({tag, "_rise_wait"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    tick(3);
    for (int i = 0; i < 4000; i++) begin
      if (!busy && (txq.size() == 0 || !enable)) break;
      tick(1);
    end
    ok = !busy;
    chk({tag, "_idle_wait"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic check_results(input string tag, input int unsigned falls);
    int unsigned n;
    logic [7:0]  e, p;
    logic [31:0] got;
    n = exp_w.size();
    chk({tag, "_pops"}, pops - p0, n);
    chk({tag, "_pushes"}, pushes - q0, n);
    chk({tag, "_rises"}, rises - r0, 8 * n);
    chk({tag, "_cs_falls"}, cs_falls - f0, falls);
    chk({tag, "_end_cs_busy"}, {30'b0, cs_n, busy}, 32'd2);
    for (int i = 0; i < int'(n); i++) begin
      e = inv ? ~exp_w[i] : exp_w[i];
      got = (i < rx_got.size()) ? {24'b0, rx_got[i]} : 32'hDEAD_BEEF;
      chk({tag, "_rx_word"}, got, {24'b0, e});
      got = (i < mosi_got.size()) ? {24'b0, mosi_got[i]} : 32'hDEAD_BEEF;
      chk({tag, "_mosi_word"}, got, {24'b0, exp_w[i]});
      p = 8'(2 * (exp_d[i] + 1));
      got = (i < per_got.size()) ? {16'b0, per_got[i]} : 32'hDEAD_BEEF;
      chk({tag, "_sclk_period"}, got, {16'b0, p, p});
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_outs"}, {26'b0, cs_n, sclk, mosi, tx_rd_en, rx_wr_en, busy}, 32'b100000);
    chk({tag, "_rx_data"}, {24'b0, rx_data}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       stall_ok;
    int         nw;
    logic [7:0] d;

    // Reset state
    reset_b = 1'b0;
    tick(3);
    check_reset_outs("reset");
    reset_b = 1'b1;
    tick(2);

    // Single loopback word, div=1
    begin_test(); inv = 1'b0; clk_div = 8'd1;
    push_word(8'hA5, 8'd1);
    enable = 1'b1;
    wait_idle("t1");
    check_results("t1", 1);

    // Back-to-back words keep cs_n low
    begin_test(); clk_div = 8'd1;
    push_word(8'h3C, 8'd1); push_word(8'hFF, 8'd1); push_word(8'h00, 8'd1);
    wait_idle("t2");
    check_results("t2", 1);

    // RX full at word end stalls the write-back
    begin_test(); clk_div = 8'd1;
    push_word(8'hE7, 8'd1);
    wait_rises("t3", 8);
    rx_full = 1'b1;
    tick(3);
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (sclk !== 1'b0 || cs_n !== 1'b0 || rx_wr_en !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
    end
    chk("t3_stall_hold", {31'b0, stall_ok}, 32'd1);
    chk("t3_no_push_while_full", pushes - q0, 32'd0);
    rx_full = 1'b0;
    wait_idle("t3");
    check_results("t3", 1);

    // enable dropped mid-word: word finishes, no second pop
    begin_test(); clk_div = 8'd1;
    push_word(8'h96, 8'd1); push_word(8'h69, 8'd1);
    wait_rises("t4", 3);
    enable = 1'b0;
    wait_idle("t4a");
    chk("t4_one_pop", pops - p0, 32'd1);
    chk("t4_one_push", pushes - q0, 32'd1);
    chk("t4_cs_high", {31'b0, cs_n}, 32'd1);
    enable = 1'b1;
    wait_idle("t4b");
    check_results("t4", 2);

    // Reset mid-word aborts the word
    begin_test(); clk_div = 8'd1;
    push_word(8'h5A, 8'd1);
    wait_rises("t5", 5);
    reset_b = 1'b0;
    tick(1);
    check_reset_outs("t5_midword_reset");
    reset_b = 1'b1;
    tick(6);
    chk("t5_no_push", pushes - q0, 32'd0);
    chk("t5_one_pop", pops - p0, 32'd1);
    chk("t5_idle", {31'b0, busy}, 32'd0);

    // Reset glitch between clock edges is ignored
    begin_test(); clk_div = 8'd1;
    push_word(8'hC3, 8'd1);
    wait_rises("t5g", 2);
    reset_b = 1'b0;
    #3;
    reset_b = 1'b1;
    wait_idle("t5g");
    check_results("t5g", 1);

    // clk_div=0, then a mid-word divider change applies to the next word only
    begin_test(); clk_div = 8'd0;
    push_word(8'h81, 8'd0);
    wait_idle("t6a");
    check_results("t6a", 1);
    begin_test(); clk_div = 8'd0;
    push_word(8'h7E, 8'd0); push_word(8'hB4, 8'd3);
    wait_rises("t6b", 3);
    clk_div = 8'd3;
    wait_idle("t6b");
    check_results("t6b", 1);

    // Randomized runs against the reference model
    for (int it = 0; it < 8; it++) begin
      begin_test();
      nw  = int'($urandom_range(1, 3));
      d   = 8'($urandom_range(0, 3));
      inv = 1'($urandom_range(0, 1));
      clk_div = d;
      for (int k = 0; k < nw; k++) push_word(8'($urandom), d);
      wait_idle("rnd");
      check_results("rnd", 1);
    end
    inv = 1'b0;

    chk("fifo_no_pop_when_empty", bad_pop, 32'd0);
    chk("fifo_no_push_when_full", bad_push, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
